// File: rtl/dm_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dm_responder : MEM-stage data memory with wait states, byte-lane stores,
//                range/alignment checking and a post-reset clearing sweep.
//                Optional store log: define DM_WRITE_LOG_EN.
// Revision     : 1.0  initial release
// ----------------------------------------------------------------------------
module dm_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        addr_err
);

  localparam int          DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  C_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clear_ptr_q, clear_ptr_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    addr_err_q, addr_err_d;

  logic [31:0]             mem_q [DEPTH];

  logic                    w_live;
  logic                    w_we;
  logic [3:0]              w_be;
  logic [31:0]             w_addr;
  logic [31:0]             w_wdata;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [31:0]             w_word;
  logic [31:0]             w_mask;
  logic [31:0]             w_merged;
  logic                    w_range_err;
  logic                    w_be_legal;
  logic                    w_err;
  logic                    w_enter_resp;
  logic                    w_mem_we;
  logic [ADDR_WIDTH-1:0]   w_mem_idx;
  logic [31:0]             w_mem_wdata;

  // With zero wait states the response is formed on the accepting edge, so
  // in IDLE the request fields come straight from the ports.
  assign w_live  = (state_q == S_IDLE);
  assign w_we    = w_live ? we    : we_q;
  assign w_be    = w_live ? be    : be_q;
  assign w_addr  = w_live ? addr  : addr_q;
  assign w_wdata = w_live ? wdata : wdata_q;

  assign w_idx       = w_addr[ADDR_WIDTH+1:2];
  assign w_word      = mem_q[w_idx];
  assign w_range_err = ((w_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign w_mask      = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  assign w_merged    = (w_word & ~w_mask) | (w_wdata & w_mask);

  always_comb begin
    w_be_legal = 1'b0;
    case (w_be)
      4'b1111, 4'b0011: w_be_legal = (w_addr[1:0] == 2'd0);
      4'b1100:          w_be_legal = (w_addr[1:0] == 2'd2);
      4'b0001:          w_be_legal = (w_addr[1:0] == 2'd0);
      4'b0010:          w_be_legal = (w_addr[1:0] == 2'd1);
      4'b0100:          w_be_legal = (w_addr[1:0] == 2'd2);
      4'b1000:          w_be_legal = (w_addr[1:0] == 2'd3);
      default:          w_be_legal = 1'b0;
    endcase
  end

  assign w_err = w_range_err | (w_we & ~w_be_legal);

  always_comb begin
    state_d      = state_q;
    clear_ptr_d  = clear_ptr_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    rdata_d      = 32'd0;
    addr_err_d   = 1'b0;
    w_enter_resp = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_idx    = w_idx;
    w_mem_wdata  = w_merged;

    case (state_q)
      S_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_idx   = clear_ptr_q;
        w_mem_wdata = 32'd0;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (&clear_ptr_q) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          be_d    = be;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = C_WAIT;
          if (C_WAIT == 4'd0) begin
            w_enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          w_enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase

    // Store commit and response capture share the edge that enters RESP.
    if (w_enter_resp) begin
      state_d      = S_RESP;
      resp_valid_d = 1'b1;
      addr_err_d   = w_err;
      rdata_d      = w_err ? 32'd0 : (w_we ? w_merged : w_word);
      w_mem_we     = w_we & ~w_err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      clear_ptr_q  <= '0;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      be_q         <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_ptr_q  <= clear_ptr_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      addr_err_q   <= addr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      mem_q[w_mem_idx] <= w_mem_wdata;
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign addr_err   = addr_err_q;

`ifdef DM_WRITE_LOG_EN
  logic [31:0] pc_q;
  logic [31:0] w_pc;

  assign w_pc = w_live ? pc : pc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= 32'd0;
    end else if (w_live && req) begin
      pc_q <= pc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we && (state_q != S_CLEAR)) begin
      $display("@%h: *%h <= %h", w_pc, {w_addr[31:2], 2'b00}, w_merged);
    end
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^pc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dm_responder : randomized self-checking bench against a word-array model.
// Revision        : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_dm_responder;

  localparam int AW    = 4;
  localparam int WAITC = 2;
  localparam int DEPTH = 2 ** AW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        addr_err;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] model_mem [DEPTH];

  dm_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAITC)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .be         (be),
    .addr       (addr),
    .wdata      (wdata),
    .pc         (pc),
    .ready      (ready),
    .resp_valid (resp_valid),
    .rdata      (rdata),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
  endfunction

  // Behavioural expectation straight from the access rules.
  function automatic void model_access(input logic w, input logic [3:0] b, input logic [31:0] a,
                                       input logic [31:0] d, output logic [31:0] rd,
                                       output logic err);
    int off, idx;
    logic legal;
    logic [31:0] word;
    off   = int'(a[1:0]);
    idx   = int'(a[5:2]);
    legal = (b == 4'hF && off == 0) || (b == 4'h3 && off == 0) ||
            (b == 4'hC && off == 2) || (b == 4'(1 << off));
    if (a >= 32'(4 * DEPTH) || (w && !legal)) begin
      rd  = 32'd0;
      err = 1'b1;
    end else begin
      word = model_mem[idx];
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (b[k]) word[8*k +: 8] = d[8*k +: 8];
        model_mem[idx] = word;
      end
      rd  = word;
      err = 1'b0;
    end
  endfunction

  task automatic wait_ready(input string tag, output bit ok);
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = ready;
    if (!ok) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_req(input string tag, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
    logic [31:0] erd;
    logic        eerr;
    bit          ok;
    int          n;
    wait_ready(tag, ok);
    if (!ok) return;
    req = 1'b1; we = w; be = b; addr = a; wdata = d; pc = $urandom;
    model_access(w, b, a, d, erd, eerr);
    @(negedge clk);
    // Scramble inputs after acceptance; they must have no effect.
    req = 1'b0; we = 1'($urandom); be = 4'($urandom); addr = $urandom; wdata = $urandom;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(WAITC));
    check({tag, "_rdata"}, rdata, erd);
    check({tag, "_err"}, 32'(addr_err), 32'(eerr));
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_rd_idle"}, rdata | 32'(addr_err), 32'd0);
  endtask

  task automatic count_clear(input string tag);
    int n = 0;
    while (!ready && n < 100) begin
      check({tag, "_no_resp"}, 32'(resp_valid), 32'd0);
      n++;
      @(negedge clk);
    end
    check({tag, "_clear_cycles"}, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    logic [3:0]  rb;
    logic [31:0] ra;
    int          acc[$];
    bit          ok;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_outs", {30'd0, resp_valid, addr_err} | rdata, 32'd0);
    reset = 1'b0;
    count_clear("boot");

    for (int i = 0; i < DEPTH; i++) do_req("zero_load", 1'b0, 4'hF, 32'(4 * i), 32'd0);

    do_req("st_full", 1'b1, 4'hF, 32'h8, 32'hDEADBEEF);
    do_req("ld_full", 1'b0, 4'h0, 32'h8, 32'd0);
    do_req("st_byte", 1'b1, 4'b0010, 32'h9, 32'h00005500);
    do_req("st_half", 1'b1, 4'b1100, 32'hA, 32'h12340000);
    do_req("err_align", 1'b1, 4'b0001, 32'h9, 32'hFFFFFFFF);
    do_req("err_be0", 1'b1, 4'b0000, 32'h8, 32'hFFFFFFFF);
    do_req("err_range", 1'b0, 4'hF, 32'(1 << (AW + 2)), 32'd0);
    do_req("err_range_st", 1'b1, 4'hF, 32'h8000_0008, 32'h1);
    do_req("ld_after_err", 1'b0, 4'hF, 32'hB, 32'd0);

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 3))
        0: begin rb = 4'hF; ra = {26'd0, 4'($urandom), 2'd0}; end
        1: begin rb = 4'($urandom); ra = {26'd0, 6'($urandom)}; end
        2: begin ra = {26'd0, 6'($urandom)}; rb = 4'(1 << ra[1:0]); end
        default: begin rb = 4'($urandom); ra = $urandom | 32'h40; end
      endcase
      do_req("rand", 1'($urandom), rb, ra, $urandom);
    end
    for (int i = 0; i < DEPTH; i++) do_req("sweep", 1'b0, 4'hF, 32'(4 * i), 32'd0);

    wait_ready("thru", ok);
    if (ok) begin
      req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h10;
      for (int i = 0; i < 40; i++) begin
        if (ready) acc.push_back(cyc);
        @(negedge clk);
      end
      req = 1'b0;
      check("thru_count", 32'(acc.size()), 32'(40 / (WAITC + 2)));
      for (int i = 1; i < acc.size() && i < 5; i++)
        check("thru_gap", 32'(acc[i] - acc[i-1]), 32'(WAITC + 2));
      repeat (WAITC + 3) @(negedge clk);
    end

    do_req("pre_mid", 1'b1, 4'hF, 32'h0, 32'hCAFEF00D);
    wait_ready("mid", ok);
    if (ok) begin
      req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h4; wdata = 32'h1;
      @(negedge clk);
      req = 1'b0;
      reset = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check("mid_no_resp", 32'(resp_valid), 32'd0);
      end
      reset = 1'b0;
      model_clear();
      count_clear("mid");
      do_req("mid_ld4", 1'b0, 4'hF, 32'h4, 32'd0);
      do_req("mid_ld0", 1'b0, 4'hF, 32'h0, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
